// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : Load/store stage after the ALU: one-outstanding data bus,
//               lane alignment / extension, registered writeback and exceptions.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int cXLEN    = 32,
    parameter int pTimeout = 255
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iMemRead,
    input  logic             iMemWrite,
    input  logic [2:0]       iOpType,
    input  logic [cXLEN-1:0] iAddr,
    input  logic [cXLEN-1:0] iStoreData,
    input  logic [4:0]       iRdAddr,
    input  logic             iRegDv,
    input  logic [4:0]       iRegAddr,
    input  logic [cXLEN-1:0] iRegData,
    output logic             oStall,
    output logic             oMemReq,
    output logic             oMemWe,
    output logic [cXLEN-1:0] oMemAddr,
    output logic [cXLEN-1:0] oMemWdata,
    output logic [3:0]       oMemBe,
    input  logic             iMemGnt,
    input  logic             iMemRvalid,
    input  logic [cXLEN-1:0] iMemRdata,
    output logic             oWbDv,
    output logic [4:0]       oWbAddr,
    output logic [cXLEN-1:0] oWbData,
    output logic             oExc,
    output logic [1:0]       oExcCause
);

    localparam int c_CNT_W = (pTimeout < 2) ? 1 : $clog2(pTimeout + 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'((pTimeout == 0) ? 0 : pTimeout - 1);
    localparam logic c_TO_EN = (pTimeout != 0);

    localparam logic [1:0] c_SZ_B = 2'd0;
    localparam logic [1:0] c_SZ_H = 2'd1;
    localparam logic [1:0] c_SZ_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t r_state, w_nextState;

    logic [cXLEN-1:0]   r_addr;
    logic [cXLEN-1:0]   r_wdata;
    logic [3:0]         r_be;
    logic               r_we;
    logic [4:0]         r_rd;
    logic [1:0]         r_size;
    logic               r_unsigned;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_wbDv;
    logic [4:0]         r_wbAddr;
    logic [cXLEN-1:0]   r_wbData;
    logic               r_exc;
    logic [1:0]         r_excCause;

    logic               w_memOp;
    logic               w_legal;
    logic               w_misaligned;
    logic               w_accept;
    logic [1:0]         w_size;
    logic [3:0]         w_be;
    logic [cXLEN-1:0]   w_wdata;
    logic               w_timeout;
    logic [cXLEN-1:0]   w_shifted;
    logic [cXLEN-1:0]   w_loadData;

    assign w_memOp   = iMemRead | iMemWrite;
    assign w_timeout = c_TO_EN && (r_cnt == c_TO_LAST);

    // Unsigned variants exist only for loads; read wins when both strobes are set
    always_comb begin
        w_legal = 1'b1;
        w_size  = c_SZ_W;
        case (iOpType)
            3'b000:  w_size = c_SZ_B;
            3'b001:  w_size = c_SZ_H;
            3'b010:  w_size = c_SZ_W;
            3'b100: begin w_size = c_SZ_B; w_legal = iMemRead; end
            3'b101: begin w_size = c_SZ_H; w_legal = iMemRead; end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_misaligned = ((w_size == c_SZ_H) && iAddr[0]) ||
                          ((w_size == c_SZ_W) && (iAddr[1:0] != 2'b00));
    assign w_accept     = (r_state == IDLE) && w_memOp && w_legal && !w_misaligned;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = iStoreData;
        case (w_size)
            c_SZ_B: begin
                w_be    = 4'b0001 << iAddr[1:0];
                w_wdata = {(cXLEN/8){iStoreData[7:0]}};
            end
            c_SZ_H: begin
                w_be    = 4'b0011 << iAddr[1:0];
                w_wdata = {(cXLEN/16){iStoreData[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_shifted = iMemRdata >> {r_addr[1:0], 3'b000};

    always_comb begin
        case (r_size)
            c_SZ_B:  w_loadData = {{(cXLEN-8){~r_unsigned & w_shifted[7]}}, w_shifted[7:0]};
            c_SZ_H:  w_loadData = {{(cXLEN-16){~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            default: w_loadData = iMemRdata;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        oStall      = (r_state != IDLE);
        oMemReq     = 1'b0;
        oMemWe      = 1'b0;
        oMemAddr    = '0;
        oMemWdata   = '0;
        oMemBe      = 4'b0000;
        case (r_state)
            IDLE: begin
                if (w_accept) w_nextState = REQ;
            end
            REQ: begin
                oMemReq   = 1'b1;
                oMemWe    = r_we;
                oMemAddr  = {r_addr[cXLEN-1:2], 2'b00};
                oMemWdata = r_wdata;
                oMemBe    = r_be;
                if (iMemGnt) w_nextState = r_we ? IDLE : WAIT;
            end
            WAIT: begin
                if (iMemRvalid || w_timeout) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= 4'b0000;
            r_we       <= 1'b0;
            r_rd       <= 5'd0;
            r_size     <= c_SZ_W;
            r_unsigned <= 1'b0;
            r_cnt      <= '0;
            r_wbDv     <= 1'b0;
            r_wbAddr   <= 5'd0;
            r_wbData   <= '0;
            r_exc      <= 1'b0;
            r_excCause <= 2'b00;
        end else begin
            r_wbDv     <= 1'b0;
            r_wbAddr   <= 5'd0;
            r_wbData   <= '0;
            r_exc      <= 1'b0;
            r_excCause <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr     <= iAddr;
                        r_wdata    <= w_wdata;
                        r_be       <= w_be;
                        r_we       <= !iMemRead;
                        r_rd       <= iRdAddr;
                        r_size     <= w_size;
                        r_unsigned <= iOpType[2];
                    end else if (w_memOp) begin
                        r_exc      <= 1'b1;
                        r_excCause <= w_legal ? 2'b01 : 2'b10;
                    end else if (iRegDv) begin
                        r_wbDv   <= 1'b1;
                        r_wbAddr <= iRegAddr;
                        r_wbData <= iRegData;
                    end
                end
                REQ: begin
                    if (iMemGnt) r_cnt <= '0;
                end
                WAIT: begin
                    // A load to x0 still completes on the bus but never writes back
                    if (iMemRvalid) begin
                        if (r_rd != 5'd0) begin
                            r_wbDv   <= 1'b1;
                            r_wbAddr <= r_rd;
                            r_wbData <= w_loadData;
                        end
                    end else if (w_timeout) begin
                        r_exc      <= 1'b1;
                        r_excCause <= 2'b11;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign oWbDv     = r_wbDv;
    assign oWbAddr   = r_wbAddr;
    assign oWbData   = r_wbData;
    assign oExc      = r_exc;
    assign oExcCause = r_excCause;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Directed self-checking bench for mem_access_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iMemRead = 1'b0, iMemWrite = 1'b0;
    logic [2:0]  iOpType = 3'b000;
    logic [31:0] iAddr = '0, iStoreData = '0;
    logic [4:0]  iRdAddr = '0;
    logic        iRegDv = 1'b0;
    logic [4:0]  iRegAddr = '0;
    logic [31:0] iRegData = '0;
    logic        oStall, oMemReq, oMemWe;
    logic [31:0] oMemAddr, oMemWdata;
    logic [3:0]  oMemBe;
    logic        iMemGnt = 1'b0, iMemRvalid = 1'b0;
    logic [31:0] iMemRdata = '0;
    logic        oWbDv;
    logic [4:0]  oWbAddr;
    logic [31:0] oWbData;
    logic        oExc;
    logic [1:0]  oExcCause;

    int nVec = 0;
    int nErr = 0;

    mem_access_stage #(.cXLEN(32), .pTimeout(4)) dut (
        .iClk(iClk), .iRst(iRst),
        .iMemRead(iMemRead), .iMemWrite(iMemWrite), .iOpType(iOpType),
        .iAddr(iAddr), .iStoreData(iStoreData), .iRdAddr(iRdAddr),
        .iRegDv(iRegDv), .iRegAddr(iRegAddr), .iRegData(iRegData),
        .oStall(oStall), .oMemReq(oMemReq), .oMemWe(oMemWe),
        .oMemAddr(oMemAddr), .oMemWdata(oMemWdata), .oMemBe(oMemBe),
        .iMemGnt(iMemGnt), .iMemRvalid(iMemRvalid), .iMemRdata(iMemRdata),
        .oWbDv(oWbDv), .oWbAddr(oWbAddr), .oWbData(oWbData),
        .oExc(oExc), .oExcCause(oExcCause)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic doLoad(input logic [2:0] op, input logic [31:0] addr, input logic [4:0] rd,
                          input logic [31:0] rdata, input logic [31:0] expData, input logic [3:0] expBe);
        iMemRead = 1'b1; iOpType = op; iAddr = addr; iRdAddr = rd;
        step();
        iMemRead = 1'b0;
        chk("ld_req", oMemReq, 1);
        chk("ld_we", oMemWe, 0);
        chk("ld_addr", oMemAddr, {addr[31:2], 2'b00});
        chk("ld_be", oMemBe, expBe);
        chk("ld_stall", oStall, 1);
        iMemGnt = 1'b1;
        step();
        iMemGnt = 1'b0;
        chk("ld_wait_req", oMemReq, 0);
        chk("ld_wait_stall", oStall, 1);
        iMemRvalid = 1'b1; iMemRdata = rdata;
        step();
        iMemRvalid = 1'b0;
        chk("ld_wbdv", oWbDv, (rd != 0) ? 1 : 0);
        chk("ld_wbaddr", oWbAddr, (rd != 0) ? rd : 0);
        chk("ld_wbdata", oWbData, (rd != 0) ? expData : 0);
        chk("ld_exc", oExc, 0);
        chk("ld_done_stall", oStall, 0);
        step();
        chk("ld_wbdv_pulse", oWbDv, 0);
    endtask

    task automatic doStore(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                           input int gntDelay, input logic [3:0] expBe, input logic [31:0] expWdata);
        iMemWrite = 1'b1; iOpType = op; iAddr = addr; iStoreData = data;
        step();
        iMemWrite = 1'b0;
        for (int i = 0; i <= gntDelay; i++) begin
            iMemGnt = (i == gntDelay);
            chk("st_req", oMemReq, 1);
            chk("st_we", oMemWe, 1);
            chk("st_addr", oMemAddr, {addr[31:2], 2'b00});
            chk("st_be", oMemBe, expBe);
            chk("st_wdata", oMemWdata, expWdata);
            step();
        end
        iMemGnt = 1'b0;
        chk("st_idle_stall", oStall, 0);
        chk("st_idle_req", oMemReq, 0);
        chk("st_no_wb", oWbDv, 0);
    endtask

    task automatic doBadOp(input logic rd, input logic [2:0] op, input logic [31:0] addr, input logic [1:0] cause);
        iMemRead = rd; iMemWrite = !rd; iOpType = op; iAddr = addr; iRdAddr = 5'd4;
        step();
        iMemRead = 1'b0; iMemWrite = 1'b0;
        chk("bad_exc", oExc, 1);
        chk("bad_cause", oExcCause, cause);
        chk("bad_req", oMemReq, 0);
        chk("bad_wb", oWbDv, 0);
        chk("bad_stall", oStall, 0);
        step();
        chk("bad_exc_pulse", oExc, 0);
        chk("bad_req_after", oMemReq, 0);
    endtask

    initial begin
        #1;
        chk("rst_stall", oStall, 0);
        chk("rst_req", oMemReq, 0);
        chk("rst_wbdv", oWbDv, 0);
        chk("rst_exc", oExc, 0);
        step();
        iRst = 1'b0;
        step();

        // sign/zero extension across lanes and sizes
        doLoad(3'b000, 32'h0000_0103, 5'd5, 32'h8012_3456, 32'hFFFF_FF80, 4'b1000);
        doLoad(3'b100, 32'h0000_0103, 5'd5, 32'h8012_3456, 32'h0000_0080, 4'b1000);
        doLoad(3'b000, 32'h0000_0100, 5'd6, 32'h1111_117F, 32'h0000_007F, 4'b0001);
        doLoad(3'b001, 32'h0000_0102, 5'd8, 32'h8001_7FFF, 32'hFFFF_8001, 4'b1100);
        doLoad(3'b101, 32'h0000_0102, 5'd8, 32'h8001_7FFF, 32'h0000_8001, 4'b1100);
        doLoad(3'b001, 32'h0000_0100, 5'd9, 32'h8001_7FFF, 32'h0000_7FFF, 4'b0011);
        doLoad(3'b010, 32'h0000_0104, 5'd31, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111);

        // stores with byte-lane replication and grant delays
        doStore(3'b001, 32'h0000_0202, 32'h1234_ABCD, 3, 4'b1100, 32'hABCD_ABCD);
        doStore(3'b000, 32'h0000_0201, 32'h0000_0055, 0, 4'b0010, 32'h5555_5555);
        doStore(3'b010, 32'h0000_0208, 32'hDEAD_BEEF, 1, 4'b1111, 32'hDEAD_BEEF);

        // misaligned / illegal ops
        doBadOp(1'b1, 3'b010, 32'h0000_0101, 2'b01);
        doBadOp(1'b1, 3'b001, 32'h0000_0103, 2'b01);
        doBadOp(1'b1, 3'b011, 32'h0000_0100, 2'b10);
        doBadOp(1'b0, 3'b100, 32'h0000_0100, 2'b10);

        // bus timeout after four WAIT cycles
        iMemRead = 1'b1; iOpType = 3'b010; iAddr = 32'h0000_0300; iRdAddr = 5'd7;
        step();
        iMemRead = 1'b0; iMemGnt = 1'b1;
        chk("to_req", oMemReq, 1);
        step();
        iMemGnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_wait_stall", oStall, 1);
            chk("to_wait_exc", oExc, 0);
            step();
        end
        chk("to_exc", oExc, 1);
        chk("to_cause", oExcCause, 2'b11);
        chk("to_stall", oStall, 0);
        chk("to_wb", oWbDv, 0);
        iMemRvalid = 1'b1; iMemRdata = 32'h1234_5678;
        step();
        iMemRvalid = 1'b0;
        chk("to_late_rvalid_wb", oWbDv, 0);
        chk("to_exc_pulse", oExc, 0);

        // pass-through then load to x0
        iRegDv = 1'b1; iRegAddr = 5'd3; iRegData = 32'h0000_DEAD;
        step();
        iRegDv = 1'b0;
        chk("pt_wbdv", oWbDv, 1);
        chk("pt_wbaddr", oWbAddr, 5'd3);
        chk("pt_wbdata", oWbData, 32'h0000_DEAD);
        doLoad(3'b010, 32'h0000_0400, 5'd0, 32'h9999_9999, 32'h0, 4'b1111);

        // read wins when both strobes set: a load request appears
        iMemRead = 1'b1; iMemWrite = 1'b1; iOpType = 3'b010; iAddr = 32'h0000_0500; iRdAddr = 5'd9;
        step();
        iMemRead = 1'b0; iMemWrite = 1'b0;
        chk("prio_req", oMemReq, 1);
        chk("prio_we", oMemWe, 0);
        iMemGnt = 1'b1;
        step();
        iMemGnt = 1'b0;
        chk("rstw_stall", oStall, 1);

        // asynchronous reset while in WAIT
        #2 iRst = 1'b1;
        #1;
        chk("arst_stall", oStall, 0);
        chk("arst_req", oMemReq, 0);
        chk("arst_addr", oMemAddr, 0);
        chk("arst_wbdv", oWbDv, 0);
        chk("arst_exc", oExc, 0);
        step();
        iRst = 1'b0;
        iMemRvalid = 1'b1; iMemRdata = 32'hFFFF_FFFF;
        step();
        iMemRvalid = 1'b0;
        chk("arst_late_wb", oWbDv, 0);
        chk("arst_late_stall", oStall, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
`default_nettype wire
